multi_cycle_control: RTL
========================

# multi_cycle_control

Multi-cycle MIPS control unit: successor to the single-cycle opcode decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the shared-ALU / single-memory datapath, stalls on a memory ready handshake, and flags illegal opcodes. It sits between the instruction register's opcode field and every datapath mux and enable.

## Interface
- ALUOP_W, default 4: ALUOp width.
- HAS_LDST, default 1: 1 supports lw/sw; 0 decodes lw/sw as illegal.
- clk  in  1  system clock; one clock.
- reset_n  in  1  reset, asynchronous and active-low.
- op  in  6  opcode from instruction register (IR[31:26]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCEn  out  1  PC write enable (unconditional or branch-qualified).
- IorD  out  1  0 = memory address from PC, 1 = from ALUOut.
- MemRead, MemWrite, IRWrite  out  1 each  memory/IR strobes.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = sign-ext imm<<2.
- ALUOp  out  ALUOP_W  ADD 0000, SUB 0001, funct 0010, XOR 0011, SLT 0100, AND 0101.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31.
- RegWrite, MemtoReg, PCToReg, ExtMode  out  1 each; ExtMode 1 = sign, 0 = zero extension.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, BRANCH, JAL, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ILLEGAL.
- Every output is 0 unless listed for the current state. No x values are ever driven.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite=PCEn=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut).
  - Latches op into op_q.
  - Dispatch: 000000 → EXEC_R; 001100/001110/001010 → EXEC_I; 000100/000101 → BRANCH; 000011 → JAL; 100011/101011 → MEM_ADDR (if HAS_LDST); anything else → ILLEGAL.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=funct → WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10 → WB_ALU. Per op_q:
  - andi: ALUOp=AND, ExtMode=0.
  - xori: ALUOp=XOR, ExtMode=0.
  - slti: ALUOp=SLT, ExtMode=1.
- WB_ALU: RegWrite=1, MemtoReg=0, RegDst = 01 for R-type, 00 for I-type → FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01.
  - PCEn = zero for beq, ~zero for bne.
  - → FETCH.
- JAL: PCEn=1, PCSource=10, RegWrite=1, RegDst=10, PCToReg=1 (writes PC+4, already in PC) → FETCH.
- MEM_ADDR:
  - Drives ALUSrcA=1, ALUSrcB=10, ExtMode=1, ALUOp=ADD.
  - → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1, MemRead=1. Holds until mem_ready=1, then → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=00 → FETCH.
- MEM_WR:
  - Drives IorD=1, MemWrite=1.
  - Holds until mem_ready=1, then → FETCH.
  - MemWrite stays high for the whole wait, so memory must not write twice.
- ILLEGAL: illegal=1, no writes → FETCH. Because the PC already advanced, execution skips the illegal instruction.

## Timing
- Reset:
  - While reset_n=0: state=FETCH, op_q=0, and all outputs forced to 0, including the MemRead that FETCH would otherwise drive.
  - Reset asserted mid-instruction aborts it immediately; any pending write strobe drops in the same instant.
- Transitions occur on the clk rising edge.
- Outputs are combinational from state (plus mem_ready/zero/op_q), with no added latency.
- Cycle counts with zero wait states:
  - R-type, I-type, sw: 4.
  - beq, bne, jal, illegal: 3.
  - lw: 5.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready is ignored in every other state.
- op may change after FETCH without effect; op_q governs all post-DECODE states.

## Test plan
- Reset: hold reset_n=0 with mem_ready=1 → all outputs 0 and state=FETCH. Release → FETCH with MemRead=1, PCEn=1 in the first cycle.
- R-type (op=000000), mem_ready=1 → states FETCH, DECODE, EXEC_R, WB_ALU. RegWrite=1 and RegDst=01 only in cycle 4.
- Branches, each from FETCH:
  - beq with zero=1 → PCEn=1, PCSource=01 in cycle 3.
  - beq with zero=0 → PCEn=0.
  - bne with zero=0 → PCEn=1.
- lw with mem_ready low for 3 cycles in MEM_RD → 8 cycles total. MemRead and IorD stay high throughout; RegWrite=1, MemtoReg=1 only in MEM_WB.
- jal and andi:
  - jal → cycle 3 shows PCEn=1, PCSource=10, RegDst=10, PCToReg=1, RegWrite=1.
  - andi → ALUOp=0101, ExtMode=0.
- Illegal and abort:
  - op=111111 → illegal pulses exactly once in cycle 3, then FETCH.
  - With HAS_LDST=0, lw is also illegal.
  - reset_n dropped during MEM_WR → MemWrite falls without waiting for a clock edge.

Source files
------------

// File: rtl/multi_cycle_control_if.sv
// Control-unit bus for the multi-cycle MIPS datapath: opcode and status flags go in,
// mux selects and enables come out.
interface multi_cycle_control_if #(
    parameter int unsigned ALUOP_W = 4
);
    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               PCEn;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSource;
    logic [1:0]         RegDst;
    logic               RegWrite;
    logic               MemtoReg;
    logic               PCToReg;
    logic               ExtMode;
    logic               illegal;
    logic [3:0]         state;

    modport slave (
        input  op, zero, mem_ready,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               RegDst, RegWrite, MemtoReg, PCToReg, ExtMode, illegal, state
    );

    modport master (
        output op, zero, mem_ready,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               RegDst, RegWrite, MemtoReg, PCToReg, ExtMode, illegal, state
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM stepping each instruction through fetch, decode,
// execute, memory and writeback, with memory-ready stalls and illegal-opcode flagging.
module multi_cycle_control #(
    parameter int unsigned ALUOP_W  = 4,
    parameter bit          HAS_LDST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multi_cycle_control_if.slave   bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StWbAlu   = 4'd4,
        StBranch  = 4'd5,
        StJal     = 4'd6,
        StMemAddr = 4'd7,
        StMemRd   = 4'd8,
        StMemWb   = 4'd9,
        StMemWr   = 4'd10,
        StIllegal = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(4'b0000);
    localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(4'b0001);
    localparam logic [ALUOP_W-1:0] AluFunct = ALUOP_W'(4'b0010);
    localparam logic [ALUOP_W-1:0] AluXor   = ALUOP_W'(4'b0011);
    localparam logic [ALUOP_W-1:0] AluSlt   = ALUOP_W'(4'b0100);
    localparam logic [ALUOP_W-1:0] AluAnd   = ALUOP_W'(4'b0101);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign bus.state = state_q;

    // Outputs are gated by reset_n directly so strobes drop the instant reset asserts.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        bus.PCEn     = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = AluAdd;
        bus.PCSource = 2'b00;
        bus.RegDst   = 2'b00;
        bus.RegWrite = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.PCToReg  = 1'b0;
        bus.ExtMode  = 1'b0;
        bus.illegal  = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                StFetch: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCEn    = bus.mem_ready;
                    if (bus.mem_ready) state_d = StDecode;
                end
                StDecode: begin
                    // Precompute the branch target into ALUOut while dispatching.
                    bus.ALUSrcB = 2'b11;
                    op_d        = bus.op;
                    case (bus.op)
                        OpRtype:               state_d = StExecR;
                        OpAndi, OpXori, OpSlti: state_d = StExecI;
                        OpBeq, OpBne:          state_d = StBranch;
                        OpJal:                 state_d = StJal;
                        OpLw, OpSw:            state_d = HAS_LDST ? StMemAddr : StIllegal;
                        default:               state_d = StIllegal;
                    endcase
                end
                StExecR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = AluFunct;
                    state_d     = StWbAlu;
                end
                StExecI: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    case (op_q)
                        OpAndi:  bus.ALUOp = AluAnd;
                        OpXori:  bus.ALUOp = AluXor;
                        OpSlti: begin
                            bus.ALUOp   = AluSlt;
                            bus.ExtMode = 1'b1;
                        end
                        default: bus.ALUOp = AluAdd;
                    endcase
                    state_d = StWbAlu;
                end
                StWbAlu: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = (op_q == OpRtype) ? 2'b01 : 2'b00;
                    state_d      = StFetch;
                end
                StBranch: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUOp    = AluSub;
                    bus.PCSource = 2'b01;
                    bus.PCEn     = (op_q == OpBne) ? ~bus.zero : bus.zero;
                    state_d      = StFetch;
                end
                StJal: begin
                    bus.PCEn     = 1'b1;
                    bus.PCSource = 2'b10;
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'b10;
                    bus.PCToReg  = 1'b1;
                    state_d      = StFetch;
                end
                StMemAddr: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ExtMode = 1'b1;
                    state_d     = (op_q == OpSw) ? StMemWr : StMemRd;
                end
                StMemRd: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = 1'b1;
                    if (bus.mem_ready) state_d = StMemWb;
                end
                StMemWb: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                    state_d      = StFetch;
                end
                StMemWr: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                    if (bus.mem_ready) state_d = StFetch;
                end
                StIllegal: begin
                    bus.illegal = 1'b1;
                    state_d     = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

endmodule
